// File: rtl/writeback_queue_if.sv
// Writeback queue bus: producer handshakes, register-file write port,
// decode hazard queries and the idle indication.
interface writeback_queue_if #(
  parameter int word_length   = 32,
  parameter int address_width = 5
);
  logic                     alu_valid;
  logic                     alu_ready;
  logic [address_width-1:0] alu_address;
  logic [word_length-1:0]   alu_data;

  logic                     mem_valid;
  logic                     mem_ready;
  logic [address_width-1:0] mem_address;
  logic [word_length-1:0]   mem_data;

  logic                     rf_write_enable;
  logic [address_width-1:0] rf_write_address;
  logic [word_length-1:0]   rf_data_out;

  logic [address_width-1:0] query1_address;
  logic [address_width-1:0] query2_address;
  logic                     query1_pending;
  logic                     query2_pending;

  logic                     empty;

  // Producer / decode / register-file side
  modport master (
    output alu_valid, alu_address, alu_data,
    output mem_valid, mem_address, mem_data,
    output query1_address, query2_address,
    input  alu_ready, mem_ready,
    input  rf_write_enable, rf_write_address, rf_data_out,
    input  query1_pending, query2_pending, empty
  );

  // Writeback queue side
  modport slave (
    input  alu_valid, alu_address, alu_data,
    input  mem_valid, mem_address, mem_data,
    input  query1_address, query2_address,
    output alu_ready, mem_ready,
    output rf_write_enable, rf_write_address, rf_data_out,
    output query1_pending, query2_pending, empty
  );
endinterface

// File: rtl/writeback_queue.sv
// Writeback queue: accepts results from the load/store unit (priority) and
// the ALU, buffers them in order and replays each one to the register file
// as an isolated write strobe. Also reports pending writes for hazard checks.
module writeback_queue #(
  parameter int word_length   = 32,
  parameter int address_width = 5,
  parameter int queue_depth   = 4
) (
  input  logic               clk,
  input  logic               reset,
  writeback_queue_if.slave   bus
);

  localparam int PTR_W = $clog2(queue_depth);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(queue_depth);

  localparam logic [1:0] STATE_IDLE   = 2'd0;
  localparam logic [1:0] STATE_SETUP  = 2'd1;
  localparam logic [1:0] STATE_STROBE = 2'd2;

  // Queue storage and bookkeeping
  logic [address_width-1:0] addr_mem [queue_depth];
  logic [word_length-1:0]   data_mem [queue_depth];
  logic [PTR_W-1:0]         rd_ptr_reg, wr_ptr_reg;
  logic [PTR_W:0]           count_reg;

  // Drain FSM and register-file output registers
  logic [1:0]               state_reg;
  logic                     rf_we_reg;
  logic [address_width-1:0] rf_addr_reg;
  logic [word_length-1:0]   rf_data_reg;

  logic                     has_room;
  logic                     mem_fire, alu_fire;
  logic [address_width-1:0] push_addr;
  logic [word_length-1:0]   push_data;
  logic                     push_en, pop_en;
  logic                     in_flight;
  logic [queue_depth-1:0]   slot_valid;
  logic [queue_depth-1:0]   q1_hit, q2_hit;

  // Acceptance depends only on the registered count; a same-cycle pop does
  // not open a slot for that cycle's push.
  assign has_room      = (count_reg < DEPTH_C);
  assign bus.mem_ready = !reset && has_room;
  assign bus.alu_ready = !reset && has_room && !bus.mem_valid;

  assign mem_fire  = bus.mem_valid && bus.mem_ready;
  assign alu_fire  = bus.alu_valid && bus.alu_ready;
  assign push_addr = mem_fire ? bus.mem_address : bus.alu_address;
  assign push_data = mem_fire ? bus.mem_data    : bus.alu_data;
  // Writes to register 0 are acknowledged but dropped.
  assign push_en   = (mem_fire || alu_fire) && (push_addr != '0);

  // The head can be taken whenever the FSM is not holding a write in SETUP.
  assign pop_en    = (state_reg != STATE_SETUP) && (count_reg != '0);
  assign in_flight = (state_reg != STATE_IDLE);

  // Store accepted results at the write pointer.
  always_ff @(posedge clk) begin
    if (push_en) begin
      addr_mem[wr_ptr_reg] <= push_addr;
      data_mem[wr_ptr_reg] <= push_data;
    end
  end

  // Advance the FIFO pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_en)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Drain FSM: load head, raise the strobe one cycle later, drop it the next.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= STATE_IDLE;
      rf_we_reg   <= 1'b0;
      rf_addr_reg <= '0;
      rf_data_reg <= '0;
    end else begin
      case (state_reg)
        STATE_IDLE: begin
          rf_we_reg <= 1'b0;
          if (pop_en) begin
            rf_addr_reg <= addr_mem[rd_ptr_reg];
            rf_data_reg <= data_mem[rd_ptr_reg];
            state_reg   <= STATE_SETUP;
          end
        end
        STATE_SETUP: begin
          rf_we_reg <= 1'b1;
          state_reg <= STATE_STROBE;
        end
        STATE_STROBE: begin
          rf_we_reg <= 1'b0;
          if (pop_en) begin
            rf_addr_reg <= addr_mem[rd_ptr_reg];
            rf_data_reg <= data_mem[rd_ptr_reg];
            state_reg   <= STATE_SETUP;
          end else begin
            state_reg   <= STATE_IDLE;
          end
        end
        default: begin
          rf_we_reg <= 1'b0;
          state_reg <= STATE_IDLE;
        end
      endcase
    end
  end

  assign bus.rf_write_enable  = rf_we_reg;
  assign bus.rf_write_address = rf_addr_reg;
  assign bus.rf_data_out      = rf_data_reg;

  // Per-slot occupancy and hazard address match against both queries.
  generate
    for (genvar gi = 0; gi < queue_depth; gi++) begin : g_slot
      logic [PTR_W-1:0] slot_offset;
      assign slot_offset    = PTR_W'(gi) - rd_ptr_reg;
      assign slot_valid[gi] = ({1'b0, slot_offset} < count_reg);
      assign q1_hit[gi]     = slot_valid[gi] && (addr_mem[gi] == bus.query1_address);
      assign q2_hit[gi]     = slot_valid[gi] && (addr_mem[gi] == bus.query2_address);
    end
  endgenerate

  assign bus.query1_pending = (bus.query1_address != '0) &&
                              ((|q1_hit) || (in_flight && rf_addr_reg == bus.query1_address));
  assign bus.query2_pending = (bus.query2_address != '0) &&
                              ((|q2_hit) || (in_flight && rf_addr_reg == bus.query2_address));

  assign bus.empty = (count_reg == '0) && (state_reg == STATE_IDLE);

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed scenarios followed by random traffic,
// all compared cycle by cycle against a queue-based reference model.
module tb_writeback_queue;
  localparam int WL = 32;
  localparam int AW = 5;
  localparam int QD = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  writeback_queue_if #(.word_length(WL), .address_width(AW)) bus();

  writeback_queue #(.word_length(WL), .address_width(AW), .queue_depth(QD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [WL-1:0] d;
  } ent_t;

  // Reference model: queued entries, time of the last pop, output registers.
  ent_t          mq[$];
  int            cyc = 0;
  int            last_pop = -10;
  logic [AW-1:0] m_addr = '0;
  logic [WL-1:0] m_data = '0;
  int            m_writes = 0;
  int            errors = 0;
  int            checks = 0;

  // Count rising strobe edges seen at the register file.
  int   rise_cnt = 0;
  logic we_d = 1'b0;
  always @(negedge clk) begin
    if (bus.rf_write_enable && !we_d) rise_cnt <= rise_cnt + 1;
    we_d <= bus.rf_write_enable;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit m_pend(input logic [AW-1:0] q, input bit infl);
    if (q == '0) return 1'b0;
    foreach (mq[i]) if (mq[i].a == q) return 1'b1;
    return infl && (m_addr == q);
  endfunction

  // One clock: check readies, advance model, then check registered outputs.
  task automatic step(output bit alu_acc, output bit mem_acc);
    bit   exp_mr, exp_ar, exp_we, infl;
    int   sz;
    ent_t e;
    #1;
    sz     = mq.size();
    exp_mr = !reset && (sz < QD);
    exp_ar = exp_mr && !bus.mem_valid;
    check("mem_ready", bus.mem_ready, exp_mr);
    check("alu_ready", bus.alu_ready, exp_ar);
    mem_acc = bus.mem_valid && exp_mr;
    alu_acc = bus.alu_valid && exp_ar;
    if (reset) begin
      mq.delete();
      last_pop = -10;
      m_addr   = '0;
      m_data   = '0;
    end else begin
      // A write cycle spans two edges; the next head may leave two edges after the last.
      if (sz > 0 && cyc + 1 >= last_pop + 2) begin
        e        = mq.pop_front();
        m_addr   = e.a;
        m_data   = e.d;
        last_pop = cyc + 1;
      end
      if (mem_acc && bus.mem_address != '0) begin
        e.a = bus.mem_address; e.d = bus.mem_data; mq.push_back(e);
      end else if (alu_acc && bus.alu_address != '0) begin
        e.a = bus.alu_address; e.d = bus.alu_data; mq.push_back(e);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    exp_we = (cyc == last_pop + 1);
    infl   = (cyc == last_pop) || (cyc == last_pop + 1);
    if (exp_we) m_writes++;
    check("rf_write_enable",  bus.rf_write_enable,  exp_we);
    check("rf_write_address", bus.rf_write_address, m_addr);
    check("rf_data_out",      bus.rf_data_out,      m_data);
    check("query1_pending",   bus.query1_pending,   m_pend(bus.query1_address, infl));
    check("query2_pending",   bus.query2_pending,   m_pend(bus.query2_address, infl));
    check("empty",            bus.empty,            (mq.size() == 0) && !infl);
    $display("cyc=%0d rst=%0b mv=%0b av=%0b we=%0b addr=%0d data=%08h q1p=%0b q2p=%0b empty=%0b",
             cyc, reset, bus.mem_valid, bus.alu_valid, bus.rf_write_enable,
             bus.rf_write_address, bus.rf_data_out, bus.query1_pending,
             bus.query2_pending, bus.empty);
  endtask

  task automatic idle(input int n);
    bit a, m;
    for (int i = 0; i < n; i++) step(a, m);
  endtask

  task automatic push_alu(input logic [AW-1:0] a, input logic [WL-1:0] d);
    bit acc, m;
    acc = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_address = a; bus.alu_data = d;
    for (int k = 0; k < 20 && !acc; k++) step(acc, m);
    if (!acc) check("alu_accept_timeout", 0, 1);
    bus.alu_valid = 1'b0;
  endtask

  task automatic check_strobes(input string tag);
    @(negedge clk);
    #1;
    check(tag, rise_cnt, m_writes);
  endtask

  initial begin
    bit a, m;
    reset = 1'b1;
    bus.alu_valid = 0; bus.alu_address = '0; bus.alu_data = '0;
    bus.mem_valid = 0; bus.mem_address = '0; bus.mem_data = '0;
    bus.query1_address = '0; bus.query2_address = '0;
    idle(2);
    reset = 1'b0;
    idle(1);

    // Single ALU write
    push_alu(5'd5, 32'hDEADBEEF);
    idle(6);
    check_strobes("single_write_strobes");

    // Both producers at once: load wins, ALU follows next cycle
    bus.mem_valid = 1; bus.mem_address = 5'd3; bus.mem_data = 32'h11;
    bus.alu_valid = 1; bus.alu_address = 5'd4; bus.alu_data = 32'h22;
    step(a, m);
    check("mem_first_accept", m, 1);
    check("alu_blocked", a, 0);
    bus.mem_valid = 0;
    step(a, m);
    check("alu_second_accept", a, 1);
    bus.alu_valid = 0;
    idle(8);
    check_strobes("dual_producer_strobes");

    // Backpressure with six back-to-back ALU results
    for (int i = 1; i <= 6; i++) push_alu(AW'(i), 32'hA000_0000 + 32'(i));
    idle(16);
    check_strobes("backpressure_strobes");

    // Address zero is acknowledged and dropped
    bus.query1_address = '0;
    push_alu(5'd0, 32'hFFFFFFFF);
    idle(5);
    check_strobes("addr_zero_strobes");

    // Hazard flags
    bus.query1_address = 5'd7; bus.query2_address = 5'd8;
    push_alu(5'd7, 32'h7777_0007);
    idle(6);

    // Reset during the first strobe
    push_alu(5'd9,  32'h9);
    push_alu(5'd10, 32'hA);
    push_alu(5'd11, 32'hB);
    for (int k = 0; k < 10 && !bus.rf_write_enable; k++) idle(1);
    check("strobe_before_reset", bus.rf_write_enable, 1);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(8);
    check_strobes("reset_mid_strobes");

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      reset              = ($urandom_range(0, 99) == 0);
      bus.mem_valid      = ($urandom_range(0, 2) == 0);
      bus.mem_address    = AW'($urandom_range(0, 7));
      bus.mem_data       = $urandom;
      bus.alu_valid      = ($urandom_range(0, 1) == 0);
      bus.alu_address    = AW'($urandom_range(0, 7));
      bus.alu_data       = $urandom;
      bus.query1_address = AW'($urandom_range(0, 7));
      bus.query2_address = AW'($urandom_range(0, 7));
      step(a, m);
    end
    reset = 1'b0; bus.mem_valid = 0; bus.alu_valid = 0;
    idle(20);
    check_strobes("random_strobes");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
